// File: rtl/serial_addsub_pkg.sv
// Shared types and helpers for the bit-serial add/subtract engine.
package serial_addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Bit counter width: counts 0..w-1, so clog2(w) bits suffice (w >= 2).
  function automatic int cnt_w(input int w);
    return $clog2(w);
  endfunction

endpackage

// File: rtl/fas.sv
// Single-bit full adder/subtractor cell: b is inverted when s_op=1 so a
// carry-in of 1 on the first bit yields two's-complement subtraction.
module fas (
  input  logic a,
  input  logic b,
  input  logic cin,
  input  logic s_op,
  output logic s,
  output logic cout
);

  logic b_eff;

  // Sum and majority carry on the effective (possibly inverted) b.
  always_comb begin
    b_eff = b ^ s_op;
    s     = a ^ b_eff ^ cin;
    cout  = (a & b_eff) | (a & cin) | (b_eff & cin);
  end

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial WIDTH-bit add/subtract engine: one fas cell, LSB first,
// valid/ready on both sides. Optional macro SERIAL_ADDSUB_OVF_EN enables the
// signed-overflow flag; without it out_ovf is held at 0.
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_zero,
  output logic             out_ovf
);

  localparam int CW = cnt_w(WIDTH);

  state_e           state;
  logic [WIDTH-1:0] sa, sb, res;
  logic             op, carry;
  logic [CW-1:0]    cnt;
  logic             s, cout;
  logic [WIDTH-1:0] res_nxt;
  logic             ovf_nxt;

  fas u_fas (
    .a    (sa[0]),
    .b    (sb[0]),
    .cin  (carry),
    .s_op (op),
    .s    (s),
    .cout (cout)
  );

  // Result grows from the MSB end so the last bit lands it fully aligned.
  always_comb begin
    res_nxt = {s, res[WIDTH-1:1]};
`ifdef SERIAL_ADDSUB_OVF_EN
    // In the final cycle carry holds the carry into the MSB.
    ovf_nxt = carry ^ cout;
`else
    ovf_nxt = 1'b0;
`endif
  end

  // Control FSM plus operand shifters and registered result/flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_cout  <= 1'b0;
      out_zero  <= 1'b0;
      out_ovf   <= 1'b0;
      cnt       <= '0;
      carry     <= 1'b0;
      sa        <= '0;
      sb        <= '0;
      res       <= '0;
      op        <= OP_ADD;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            sa       <= in_a;
            sb       <= in_b;
            op       <= in_op;
            carry    <= in_op;  // seeds the +1 of two's-complement subtract
            cnt      <= '0;
            res      <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          sa    <= sa >> 1;
          sb    <= sb >> 1;
          res   <= res_nxt;
          carry <= cout;
          cnt   <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            out_valid <= 1'b1;
            out_sum   <= res_nxt;
            out_cout  <= cout;
            out_zero  <= (res_nxt == '0);
            out_ovf   <= ovf_nxt;
            state     <= DONE;
          end
        end
        DONE: begin
          // IDLE always follows, so nothing is accepted on this edge.
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_addsub.sv
// Scoreboard bench for serial_addsub at WIDTH=8.
module tb_serial_addsub;

  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         zero;
    logic         ovf;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a, in_b;
  logic         in_op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout, out_zero, out_ovf;

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];

  serial_addsub #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_zero  (out_zero),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic, signed overflow from operand signs.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic op);
    exp_t         e;
    logic [W:0]   full;
    logic [W-1:0] bb;
    bb     = op ? ~b : b;
    full   = {1'b0, a} + {1'b0, bb} + (W+1)'(op);
    e.sum  = full[W-1:0];
    e.cout = full[W];
    e.zero = (full[W-1:0] == '0);
`ifdef SERIAL_ADDSUB_OVF_EN
    e.ovf  = (a[W-1] == bb[W-1]) && (full[W-1] != a[W-1]);
`else
    e.ovf  = 1'b0;
`endif
    return e;
  endfunction

  // Drive until accepted; returns with the accept edge just past (#1).
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic op);
    logic rdy;
    in_a = a; in_b = b; in_op = op; in_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      rdy = in_ready;
      @(posedge clk); #1;
      if (rdy) begin
        in_valid = 1'b0;
        in_a = ~a; in_b = a ^ b; in_op = ~op;  // must not disturb RUN
        return;
      end
    end
    in_valid = 1'b0;
    chk("accept_timeout", 64'd0, 64'd1);
  endtask

  // Full operation: accept, latency check, scoreboard compare, optional hold.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic op, input int hold);
    exp_t e;
    int   cyc;
    logic [W-1:0] s0;
    sb_q.push_back(model(a, b, op));
    out_ready = (hold == 0);
    issue(a, b, op);
    cyc = 0;
    for (int i = 1; i <= 3 * W; i++) begin
      @(posedge clk); #1;
      if (out_valid) begin cyc = i; break; end
    end
    chk("latency", 64'(cyc), 64'(W));
    e = sb_q.pop_front();
    chk("sum",  64'(out_sum),  64'(e.sum));
    chk("cout", 64'(out_cout), 64'(e.cout));
    chk("zero", 64'(out_zero), 64'(e.zero));
    chk("ovf",  64'(out_ovf),  64'(e.ovf));
    chk("busy_rdy", 64'(in_ready), 64'd0);
    if (hold > 0) begin
      s0 = out_sum;
      in_a = a ^ 8'h55; in_b = b; in_op = op; in_valid = 1'b1;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        chk("hold_vld", 64'(out_valid), 64'd1);
        chk("hold_sum", 64'(out_sum), 64'(s0));
        chk("hold_rdy", 64'(in_ready), 64'd0);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("hs_vld", 64'(out_valid), 64'd0);
      chk("hs_rdy_no_accept", 64'(in_ready), 64'd1);
      in_valid = 1'b0;
    end else begin
      @(posedge clk); #1;
      chk("hs_vld", 64'(out_valid), 64'd0);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rdy",  64'(in_ready),  64'd1);
    chk("rst_vld",  64'(out_valid), 64'd0);
    chk("rst_sum",  64'(out_sum),   64'd0);
    chk("rst_cout", 64'(out_cout),  64'd0);
    chk("rst_zero", 64'(out_zero),  64'd0);
    chk("rst_ovf",  64'(out_ovf),   64'd0);
    rst = 1'b0;

    run_op(8'h0F, 8'h01, 1'b0, 0);
    run_op(8'hFF, 8'h01, 1'b0, 0);
    run_op(8'h05, 8'h07, 1'b1, 0);
    run_op(8'h07, 8'h05, 1'b1, 0);
    run_op(8'h7F, 8'h01, 1'b0, 0);
    run_op(8'h80, 8'h01, 1'b1, 0);
    run_op(8'h33, 8'h33, 1'b1, 0);
    run_op(8'hA5, 8'h3C, 1'b0, 5);
    for (int i = 0; i < 6; i++)
      run_op(8'($urandom), 8'($urandom), 1'($urandom), i % 2);

    // Abort mid-RUN: no scoreboard entry for the discarded operation.
    out_ready = 1'b1;
    issue(8'h55, 8'h22, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_rdy", 64'(in_ready),  64'd1);
    chk("abort_vld", 64'(out_valid), 64'd0);
    chk("abort_sum", 64'(out_sum),   64'd0);
    run_op(8'h0F, 8'h01, 1'b0, 0);

    chk("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
